// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter: default field widths and source encodings.
package cdb_arbiter_pkg;

  localparam int ROB_W  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam int NUM_SRC = 3;

  typedef enum logic [1:0] {
    CDB_SRC_ALU = 2'd0,
    CDB_SRC_LSB = 2'd1,
    CDB_SRC_BRU = 2'd2
  } cdb_src_e;

  // Pointer value after source w wins; 3 is never produced.
  function automatic logic [1:0] rr_next(input logic [1:0] w);
    return (w >= 2'd2) ? 2'd0 : w + 2'd1;
  endfunction

  // The unused pointer encoding 3 is treated as 0.
  function automatic logic [1:0] rr_norm(input logic [1:0] p);
    return (p == 2'd3) ? 2'd0 : p;
  endfunction

  // Round-robin distance of source s from the current start position.
  function automatic logic [1:0] rr_dist(input logic [1:0] s, input logic [1:0] start);
    logic [2:0] t;
    t = {1'b0, s} + 3'd3 - {1'b0, start};
    if (t >= 3'd3) t = t - 3'd3;
    return t[1:0];
  endfunction

endpackage

// File: rtl/cdb_hold_slot.sv
// One-entry holding register for a single CDB source.
// Flush beats load, and load beats clear so a granted slot can refill on the same edge.
module cdb_hold_slot
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_WIDTH  = ROB_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  en_in,
  input  logic                  flush_in,
  input  logic                  load_in,
  input  logic                  clear_in,
  input  logic [ROB_WIDTH-1:0]  rob_id_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  taken_in,
  input  logic [ADDR_WIDTH-1:0] target_in,
  output logic                  valid_out,
  output logic [ROB_WIDTH-1:0]  rob_id_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  taken_out,
  output logic [ADDR_WIDTH-1:0] target_out
);

  logic                  valid_q;
  logic [ROB_WIDTH-1:0]  rob_id_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  taken_q;
  logic [ADDR_WIDTH-1:0] target_q;

  // Slot state: flush empties, load captures a request, clear frees after a grant.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q  <= 1'b0;
      rob_id_q <= '0;
      data_q   <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else if (en_in) begin
      if (flush_in) begin
        valid_q <= 1'b0;
      end else if (load_in) begin
        valid_q  <= 1'b1;
        rob_id_q <= rob_id_in;
        data_q   <= data_in;
        taken_q  <= taken_in;
        target_q <= target_in;
      end else if (clear_in) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_out  = valid_q;
  assign rob_id_out = rob_id_q;
  assign data_out   = data_q;
  assign taken_out  = taken_q;
  assign target_out = target_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Single-channel common-data-bus arbiter: ALU, LSB load-return and BRU each
// own a one-entry hold slot; a round-robin pointer picks one per cycle and the
// winner is broadcast through registered outputs. Rollback flushes everything.
// Build option: define CDB_BYPASS_EN to let a valid source with an empty slot
// compete directly and, if it wins, skip its slot (one-edge latency).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_WIDTH  = ROB_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rollback_in,
  input  logic                  alu_valid_in,
  input  logic [ROB_WIDTH-1:0]  alu_rob_id_in,
  input  logic [DATA_WIDTH-1:0] alu_data_in,
  output logic                  alu_ready_out,
  input  logic                  lsb_valid_in,
  input  logic [ROB_WIDTH-1:0]  lsb_rob_id_in,
  input  logic [DATA_WIDTH-1:0] lsb_data_in,
  output logic                  lsb_ready_out,
  input  logic                  bru_valid_in,
  input  logic [ROB_WIDTH-1:0]  bru_rob_id_in,
  input  logic [DATA_WIDTH-1:0] bru_data_in,
  output logic                  bru_ready_out,
  input  logic                  bru_taken_in,
  input  logic [ADDR_WIDTH-1:0] bru_target_in,
  output logic                  cdb_valid_out,
  output logic [ROB_WIDTH-1:0]  cdb_rob_id_out,
  output logic [DATA_WIDTH-1:0] cdb_data_out,
  output logic                  cdb_is_jump_out,
  output logic                  cdb_taken_out,
  output logic [ADDR_WIDTH-1:0] cdb_target_out,
  output logic [1:0]            cdb_src_out
);

  logic [NUM_SRC-1:0]    src_valid;
  logic [ROB_WIDTH-1:0]  src_rob    [NUM_SRC];
  logic [DATA_WIDTH-1:0] src_data   [NUM_SRC];
  logic                  src_taken  [NUM_SRC];
  logic [ADDR_WIDTH-1:0] src_target [NUM_SRC];

  logic [NUM_SRC-1:0]    hold_valid;
  logic [ROB_WIDTH-1:0]  hold_rob    [NUM_SRC];
  logic [DATA_WIDTH-1:0] hold_data   [NUM_SRC];
  logic                  hold_taken  [NUM_SRC];
  logic [ADDR_WIDTH-1:0] hold_target [NUM_SRC];

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] grant;
  logic [NUM_SRC-1:0] bypass_win;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] load;
  logic [1:0]         win;
  logic               any_grant;
  logic               active;

  logic [1:0]            rr_q;
  logic                  cdb_valid_q;
  logic [ROB_WIDTH-1:0]  cdb_rob_q,    cdb_rob_d;
  logic [DATA_WIDTH-1:0] cdb_data_q,   cdb_data_d;
  logic                  cdb_taken_q,  cdb_taken_d;
  logic [ADDR_WIDTH-1:0] cdb_target_q, cdb_target_d;
  logic                  cdb_jump_q;
  cdb_src_e              cdb_src_q;

  assign src_valid     = {bru_valid_in, lsb_valid_in, alu_valid_in};
  assign src_rob[0]    = alu_rob_id_in;
  assign src_rob[1]    = lsb_rob_id_in;
  assign src_rob[2]    = bru_rob_id_in;
  assign src_data[0]   = alu_data_in;
  assign src_data[1]   = lsb_data_in;
  assign src_data[2]   = bru_data_in;
  assign src_taken[0]  = 1'b0;
  assign src_taken[1]  = 1'b0;
  assign src_taken[2]  = bru_taken_in;
  assign src_target[0] = '0;
  assign src_target[1] = '0;
  assign src_target[2] = bru_target_in;

  // A grant only takes effect when the core is running and not flushing.
  assign active = rdy_in & ~rollback_in;

`ifdef CDB_BYPASS_EN
  assign eligible   = hold_valid | src_valid;
  assign bypass_win = grant & ~hold_valid;
`else
  assign eligible   = hold_valid;
  assign bypass_win = '0;
`endif

  // Round-robin pick: the eligible source closest to the pointer wins.
  always_comb begin
    grant = '0;
    win   = 2'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if ((grant == '0) && eligible[s] && (rr_dist(2'(s), rr_norm(rr_q)) == 2'(k))) begin
          grant[s] = 1'b1;
          win      = 2'(s);
        end
      end
    end
  end

  assign any_grant = |grant;

  assign ready = {NUM_SRC{rst_in & active}} & (~hold_valid | grant);
  assign load  = src_valid & ready & ~bypass_win;

  assign alu_ready_out = ready[0];
  assign lsb_ready_out = ready[1];
  assign bru_ready_out = ready[2];

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_slot
    cdb_hold_slot #(
      .ROB_WIDTH  (ROB_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_slot (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .en_in      (rdy_in),
      .flush_in   (rollback_in),
      .load_in    (load[s]),
      .clear_in   (grant[s]),
      .rob_id_in  (src_rob[s]),
      .data_in    (src_data[s]),
      .taken_in   (src_taken[s]),
      .target_in  (src_target[s]),
      .valid_out  (hold_valid[s]),
      .rob_id_out (hold_rob[s]),
      .data_out   (hold_data[s]),
      .taken_out  (hold_taken[s]),
      .target_out (hold_target[s])
    );
  end

  // Winner payload: straight from the source on a bypass win, else from its slot.
  always_comb begin
    cdb_rob_d    = hold_rob[0];
    cdb_data_d   = hold_data[0];
    cdb_taken_d  = 1'b0;
    cdb_target_d = '0;
    case (win)
      2'd1: begin
        cdb_rob_d  = bypass_win[1] ? src_rob[1]  : hold_rob[1];
        cdb_data_d = bypass_win[1] ? src_data[1] : hold_data[1];
      end
      2'd2: begin
        cdb_rob_d    = bypass_win[2] ? src_rob[2]    : hold_rob[2];
        cdb_data_d   = bypass_win[2] ? src_data[2]   : hold_data[2];
        cdb_taken_d  = bypass_win[2] ? src_taken[2]  : hold_taken[2];
        cdb_target_d = bypass_win[2] ? src_target[2] : hold_target[2];
      end
      default: begin
        cdb_rob_d  = bypass_win[0] ? src_rob[0]  : hold_rob[0];
        cdb_data_d = bypass_win[0] ? src_data[0] : hold_data[0];
      end
    endcase
  end

  // Broadcast register and round-robin pointer; payload fields hold when idle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_q         <= 2'd0;
      cdb_valid_q  <= 1'b0;
      cdb_rob_q    <= '0;
      cdb_data_q   <= '0;
      cdb_taken_q  <= 1'b0;
      cdb_target_q <= '0;
      cdb_jump_q   <= 1'b0;
      cdb_src_q    <= CDB_SRC_ALU;
    end else if (rdy_in) begin
      if (rollback_in) begin
        rr_q        <= 2'd0;
        cdb_valid_q <= 1'b0;
      end else if (any_grant) begin
        rr_q         <= rr_next(win);
        cdb_valid_q  <= 1'b1;
        cdb_rob_q    <= cdb_rob_d;
        cdb_data_q   <= cdb_data_d;
        cdb_taken_q  <= cdb_taken_d;
        cdb_target_q <= cdb_target_d;
        cdb_jump_q   <= (win == 2'd2);
        cdb_src_q    <= cdb_src_e'(win);
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  assign cdb_valid_out   = cdb_valid_q;
  assign cdb_rob_id_out  = cdb_rob_q;
  assign cdb_data_out    = cdb_data_q;
  assign cdb_is_jump_out = cdb_jump_q;
  assign cdb_taken_out   = cdb_taken_q;
  assign cdb_target_out  = cdb_target_q;
  assign cdb_src_out     = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (default build: requests broadcast one edge after acceptance).
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rollback_in;
  logic        alu_valid_in, lsb_valid_in, bru_valid_in;
  logic [3:0]  alu_rob_id_in, lsb_rob_id_in, bru_rob_id_in;
  logic [31:0] alu_data_in, lsb_data_in, bru_data_in;
  logic        alu_ready_out, lsb_ready_out, bru_ready_out;
  logic        bru_taken_in;
  logic [31:0] bru_target_in;
  logic        cdb_valid_out;
  logic [3:0]  cdb_rob_id_out;
  logic [31:0] cdb_data_out;
  logic        cdb_is_jump_out;
  logic        cdb_taken_out;
  logic [31:0] cdb_target_out;
  logic [1:0]  cdb_src_out;

  int n_assert = 0;
  int n_fail   = 0;

  cdb_arbiter dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .rollback_in     (rollback_in),
    .alu_valid_in    (alu_valid_in),
    .alu_rob_id_in   (alu_rob_id_in),
    .alu_data_in     (alu_data_in),
    .alu_ready_out   (alu_ready_out),
    .lsb_valid_in    (lsb_valid_in),
    .lsb_rob_id_in   (lsb_rob_id_in),
    .lsb_data_in     (lsb_data_in),
    .lsb_ready_out   (lsb_ready_out),
    .bru_valid_in    (bru_valid_in),
    .bru_rob_id_in   (bru_rob_id_in),
    .bru_data_in     (bru_data_in),
    .bru_ready_out   (bru_ready_out),
    .bru_taken_in    (bru_taken_in),
    .bru_target_in   (bru_target_in),
    .cdb_valid_out   (cdb_valid_out),
    .cdb_rob_id_out  (cdb_rob_id_out),
    .cdb_data_out    (cdb_data_out),
    .cdb_is_jump_out (cdb_is_jump_out),
    .cdb_taken_out   (cdb_taken_out),
    .cdb_target_out  (cdb_target_out),
    .cdb_src_out     (cdb_src_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_bcast(input string tag, input logic [3:0] rob, input logic [31:0] data,
                             input logic [1:0] src);
    check({tag, ".valid"}, cdb_valid_out, 1'b1);
    check({tag, ".rob"}, cdb_rob_id_out, rob);
    check({tag, ".data"}, cdb_data_out, data);
    check({tag, ".src"}, cdb_src_out, src);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; rollback_in = 1'b0;
    alu_valid_in = 1'b0; alu_rob_id_in = '0; alu_data_in = '0;
    lsb_valid_in = 1'b0; lsb_rob_id_in = '0; lsb_data_in = '0;
    bru_valid_in = 1'b0; bru_rob_id_in = '0; bru_data_in = '0;
    bru_taken_in = 1'b0; bru_target_in = '0;

    // Reset state
    #2;
    check("rst.valid", cdb_valid_out, 1'b0);
    check("rst.rob", cdb_rob_id_out, 4'd0);
    check("rst.data", cdb_data_out, 32'd0);
    check("rst.src", cdb_src_out, 2'd0);
    check("rst.ready", {alu_ready_out, lsb_ready_out, bru_ready_out}, 3'b000);

    // Single ALU request: accepted at edge 1, broadcast after edge 2
    #10;
    rst_in = 1'b1;
    alu_valid_in = 1'b1; alu_rob_id_in = 4'd3; alu_data_in = 32'h0000_00AA;
    #1;
    check("t1.ready", {alu_ready_out, lsb_ready_out, bru_ready_out}, 3'b111);
    tick();
    alu_valid_in = 1'b0;
    check("t1.early", cdb_valid_out, 1'b0);
    tick();
    check_bcast("t1", 4'd3, 32'hAA, 2'd0);
    check("t1.jump", cdb_is_jump_out, 1'b0);
    tick();
    check("t1.idle", cdb_valid_out, 1'b0);
    check("t1.hold_rob", cdb_rob_id_out, 4'd3);

    // Rollback pulse to return the pointer to 0
    rollback_in = 1'b1;
    #1;
    check("rb0.ready", {alu_ready_out, lsb_ready_out, bru_ready_out}, 3'b000);
    tick();
    rollback_in = 1'b0;

    // Full contention with pointer 0: ALU, LSB, BRU
    alu_valid_in = 1'b1; alu_rob_id_in = 4'd1; alu_data_in = 32'h11;
    lsb_valid_in = 1'b1; lsb_rob_id_in = 4'd2; lsb_data_in = 32'h22;
    bru_valid_in = 1'b1; bru_rob_id_in = 4'd3; bru_data_in = 32'h33;
    tick();
    alu_valid_in = 1'b0; lsb_valid_in = 1'b0; bru_valid_in = 1'b0;
    tick();
    check_bcast("t2a", 4'd1, 32'h11, 2'd0);
    tick();
    check_bcast("t2b", 4'd2, 32'h22, 2'd1);
    tick();
    check_bcast("t2c", 4'd3, 32'h33, 2'd2);
    tick();
    check("t2.idle", cdb_valid_out, 1'b0);

    // BRU fields, then ALU clears them
    bru_valid_in = 1'b1; bru_rob_id_in = 4'd5; bru_data_in = 32'h55;
    bru_taken_in = 1'b1; bru_target_in = 32'h0000_1040;
    tick();
    bru_valid_in = 1'b0; bru_taken_in = 1'b0; bru_target_in = '0;
    tick();
    check_bcast("t3", 4'd5, 32'h55, 2'd2);
    check("t3.jump", cdb_is_jump_out, 1'b1);
    check("t3.taken", cdb_taken_out, 1'b1);
    check("t3.target", cdb_target_out, 32'h1040);
    alu_valid_in = 1'b1; alu_rob_id_in = 4'd9; alu_data_in = 32'h99;
    tick();
    alu_valid_in = 1'b0;
    tick();
    check_bcast("t3alu", 4'd9, 32'h99, 2'd0);
    check("t3alu.jump", cdb_is_jump_out, 1'b0);
    check("t3alu.taken", cdb_taken_out, 1'b0);
    check("t3alu.target", cdb_target_out, 32'h0);
    tick();

    // ALU stream rob 0..7, one broadcast per cycle
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        alu_valid_in = 1'b1; alu_rob_id_in = 4'(i); alu_data_in = 32'h100 + 32'(i);
        #1;
        check($sformatf("t4.ready%0d", i), alu_ready_out, 1'b1);
      end else begin
        alu_valid_in = 1'b0;
      end
      tick();
      if (i >= 1) check_bcast($sformatf("t4.b%0d", i - 1), 4'(i - 1), 32'h100 + 32'(i - 1), 2'd0);
    end
    tick();
    check("t4.idle", cdb_valid_out, 1'b0);

    // Rollback with both holds full: nothing stale is broadcast
    alu_valid_in = 1'b1; alu_rob_id_in = 4'd4; alu_data_in = 32'h44;
    lsb_valid_in = 1'b1; lsb_rob_id_in = 4'd6; lsb_data_in = 32'h66;
    tick();
    alu_valid_in = 1'b0; lsb_valid_in = 1'b0;
    rollback_in = 1'b1;
    #1;
    check("t5.ready", {alu_ready_out, lsb_ready_out, bru_ready_out}, 3'b000);
    tick();
    rollback_in = 1'b0;
    check("t5.flush", cdb_valid_out, 1'b0);
    tick();
    check("t5.stale1", cdb_valid_out, 1'b0);
    tick();
    check("t5.stale2", cdb_valid_out, 1'b0);
    lsb_valid_in = 1'b1; lsb_rob_id_in = 4'd7; lsb_data_in = 32'h77;
    #1;
    check("t5.lsb_ready", lsb_ready_out, 1'b1);
    tick();
    lsb_valid_in = 1'b0;
    tick();
    check_bcast("t5.new", 4'd7, 32'h77, 2'd1);

    // Freeze with pending holds; pointer is 2 after the LSB win
    alu_valid_in = 1'b1; alu_rob_id_in = 4'd8;  alu_data_in = 32'h88;
    lsb_valid_in = 1'b1; lsb_rob_id_in = 4'd10; lsb_data_in = 32'hA0;
    bru_valid_in = 1'b1; bru_rob_id_in = 4'd11; bru_data_in = 32'hB0;
    bru_target_in = 32'h2000;
    tick();
    alu_valid_in = 1'b0; lsb_valid_in = 1'b0; bru_valid_in = 1'b0; bru_target_in = '0;
    tick();
    check_bcast("t6.bru", 4'd11, 32'hB0, 2'd2);
    check("t6.target", cdb_target_out, 32'h2000);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t6.ready%0d", i), {alu_ready_out, lsb_ready_out, bru_ready_out}, 3'b000);
      tick();
      check($sformatf("t6.frz_valid%0d", i), cdb_valid_out, 1'b1);
      check($sformatf("t6.frz_rob%0d", i), cdb_rob_id_out, 4'd11);
    end
    rdy_in = 1'b1;
    tick();
    check_bcast("t6.alu", 4'd8, 32'h88, 2'd0);
    tick();
    check_bcast("t6.lsb", 4'd10, 32'hA0, 2'd1);

    // Asynchronous reset mid-burst
    alu_valid_in = 1'b1; alu_rob_id_in = 4'd12; alu_data_in = 32'hC0;
    lsb_valid_in = 1'b1; lsb_rob_id_in = 4'd13; lsb_data_in = 32'hD0;
    tick();
    alu_valid_in = 1'b0; lsb_valid_in = 1'b0;
    tick();
    check_bcast("t7.alu", 4'd12, 32'hC0, 2'd0);
    #2;
    rst_in = 1'b0;
    #1;
    check("t7.valid", cdb_valid_out, 1'b0);
    check("t7.rob", cdb_rob_id_out, 4'd0);
    check("t7.data", cdb_data_out, 32'd0);
    check("t7.src", cdb_src_out, 2'd0);
    check("t7.ready", {alu_ready_out, lsb_ready_out, bru_ready_out}, 3'b000);
    #2;
    rst_in = 1'b1;
    tick();
    check("t7.after", cdb_valid_out, 1'b0);
    tick();
    check("t7.after2", cdb_valid_out, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Single-channel common-data-bus (CDB) arbiter for the Tomasulo core.
- Three execution sources compete for the one result bus that writes back into the reorder buffer and wakes up RS/LSB entries: ALU, LSB load-return, and branch unit (BRU).
- Each source gets a 1-entry hold slot. Grants are round-robin. Output is registered.
- The whole arbiter is flushed on ROB rollback.

Parameters:
- ROB_WIDTH, 4, bits of ROB index (16 entries)
- DATA_WIDTH, 32, result data width
- ADDR_WIDTH, 32, branch target address width

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global enable; low = freeze all state
- rollback_in  in  1  ROB mispredict flush
- alu_valid_in  in  1  ALU result request
- alu_rob_id_in  in  ROB_WIDTH  destination ROB entry
- alu_data_in  in  DATA_WIDTH  ALU result
- alu_ready_out  out  1  ALU may present a new request
- lsb_valid_in / lsb_rob_id_in / lsb_data_in / lsb_ready_out  same widths and roles for load return
- bru_valid_in / bru_rob_id_in / bru_data_in / bru_ready_out  same widths and roles; data = rd link value
- bru_taken_in  in  1  actual branch outcome
- bru_target_in  in  ADDR_WIDTH  actual next PC
- cdb_valid_out  out  1  broadcast valid
- cdb_rob_id_out  out  ROB_WIDTH  broadcast ROB index
- cdb_data_out  out  DATA_WIDTH  broadcast value
- cdb_is_jump_out  out  1  entry came from BRU
- cdb_taken_out  out  1  BRU outcome (0 if not BRU)
- cdb_target_out  out  ADDR_WIDTH  BRU target (0 if not BRU)
- cdb_src_out  out  2  0 = ALU, 1 = LSB, 2 = BRU

Behaviour:
- Reset (rst_in = 0, asynchronous):
  - all hold slots empty, rr_ptr = 0
  - every cdb_* output = 0
  - ready outputs = 0 while rst_in = 0
- rdy_in = 0: no state change; ready outputs forced 0; cdb_* outputs hold their values.
- Handshake:
  - A request transfers on a rising edge with valid & ready & rdy_in & ~rollback_in.
  - Source data must be stable while valid is high.
  - ready_s = ~hold_valid_s | grant_s (combinational). This allows one request per cycle per source under no contention.
- Arbitration (combinational, every cycle):
  - Eligible sources are those with occupied holds.
  - Priority order starts at rr_ptr: rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - At most one grant per cycle.
- On a clock edge with a grant to w:
  - cdb_* outputs load the hold-slot contents of w; cdb_valid_out = 1.
  - hold_w is freed unless a new transfer from w arrives on the same edge, in which case that request is written into hold_w.
  - rr_ptr = (w+1) mod 3.
- On a clock edge with no grant: cdb_valid_out = 0; the other cdb_* fields hold their values; rr_ptr unchanged.
- Latency: request accepted at edge N, broadcast visible after edge N+1 when uncontended. Worst case under full contention is N+3.
- Non-BRU sources drive cdb_is_jump_out = 0, cdb_taken_out = 0, cdb_target_out = 0.
- rollback_in = 1 on an edge (rdy_in high):
  - all holds cleared, cdb_valid_out = 0, rr_ptr = 0
  - incoming requests on that edge dropped; ready outputs 0 during that cycle
- Simultaneous events:
  - rollback beats any grant or transfer.
  - A reset asserted mid-operation clears everything immediately, regardless of clock.
- rr_ptr only ever takes the values 0–2; the encoding 3 is unreachable. If 3 is decoded, it is treated as 0.

Optional Feature:
- Macro: CDB_BYPASS_EN
- Defined:
  - A source with an empty hold slot and valid high is eligible directly, using the same round-robin order.
  - If such a source wins, its input goes straight to the cdb_* outputs and is not written to its hold slot. Uncontended latency = 1 edge.
  - If it loses, its input is captured into its hold slot.
- Undefined: only occupied holds are eligible (behaviour above).

Decomposition:
- constants.v holds:
  - ROB_TYPE, DATA_TYPE, ADDR_TYPE ranges
  - CDB_SRC_ALU = 0, CDB_SRC_LSB = 1, CDB_SRC_BRU = 2
- One sub-module, cdb_hold_slot: a 1-entry register (valid/rob_id/data/taken/target) with load, clear and flush inputs, instantiated three times.
- Round-robin logic stays in the top module.

Test Plan:
- Reset, then a single ALU request (rob_id 3, data 0x0000_00AA) at edge 1 → cdb_valid_out = 1, rob_id 3, data 0xAA, src 0 after edge 2 (after edge 1 with CDB_BYPASS_EN).
- All three sources hold requests (rob 1/2/3) at the same edge, rr_ptr = 0 → broadcasts in order ALU, LSB, BRU on three consecutive cycles; rr_ptr ends at 0.
- BRU request rob 5, taken = 1, target 0x0000_1040 → cdb_is_jump_out = 1, cdb_taken_out = 1, cdb_target_out = 0x1040; a following ALU broadcast shows is_jump 0, target 0.
- ALU streams valid every cycle (rob 0..7) while LSB is idle → alu_ready_out stays high and 8 broadcasts occur on 8 consecutive cycles.
- Holds full (ALU rob 4, LSB rob 6), rollback_in pulsed for one cycle → cdb_valid_out = 0 the next cycle, no stale broadcast of rob 4 or rob 6, and a new request accepted afterwards broadcasts normally.
- rdy_in low for 3 cycles with pending holds → outputs and holds frozen, ready outputs 0; draining resumes in the unchanged round-robin order. rst_in pulsed low asynchronously mid-burst → all outputs 0 immediately.
